div_unit_seq: RTL and testbench

Iterative radix-2 integer divider that executes the RV32M DIV/DIVU/REM/REMU operations. It sits directly downstream of the control unit's multiplier-extension decoder. It consumes `div_valid` and `DIVop` together with the two register operands from the datapath. It returns a registered 32-bit result with a one-cycle `div_ready` pulse, which the main FSM uses to leave its divide-wait state and write back.

---
 rtl/div_unit_seq.sv | 177 +++++++++++++++++
 tb/tb_div_unit_seq.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/div_unit_seq.sv
// div_unit_seq: iterative radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU.
// One quotient bit per cycle (32 CALC cycles), registered result with a
// single-cycle div_ready pulse in the DONE state.
// Optional feature macro: DIV_EARLY_OUT_EN (jump IDLE->DONE when the answer is
// trivial: divide by zero, signed overflow, or |dividend| < |divisor|).
// Handshake: the requester raises div_valid with stable operands and holds it
// until it samples div_ready; dropping div_valid during CALC aborts silently.

`ifndef DIV_OP_WIDTH
`define DIV_OP_WIDTH 2
`define DIV_OP_DIV   2'b00
`define DIV_OP_DIVU  2'b01
`define DIV_OP_REM   2'b10
`define DIV_OP_REMU  2'b11
`endif

module div_unit_seq (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     div_valid,
  input  logic [`DIV_OP_WIDTH-1:0] DIVop,
  input  logic [31:0]              dividend,
  input  logic [31:0]              divisor,
  output logic [31:0]              div_result,
  output logic                     div_ready
);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  state_t state;

  // Latched operation context
  logic [`DIV_OP_WIDTH-1:0] op_q;
  logic                     signed_q;
  logic                     q_neg_q;
  logic                     r_neg_q;
  logic [31:0]              a_raw_q;
  logic [31:0]              b_raw_q;
  logic [31:0]              b_mag_q;
  logic [5:0]               cnt;
  // Partial remainder; the 33rd bit only exists transiently in the trial word.
  logic [31:0]              rem_q;
  logic [31:0]              quo_q;

  // Input decode and one restoring step
  logic        in_signed;
  logic        in_q_neg;
  logic        in_r_neg;
  logic [31:0] a_mag_in;
  logic [31:0] b_mag_in;
  logic [32:0] shifted;
  logic [32:0] diff;
  logic [31:0] rem_step;
  logic [31:0] quo_step;
  logic [31:0] calc_result;

  // Negate by sign flags, apply special-case overrides, then pick quo or rem.
  function automatic logic [31:0] select_result(
    input logic [`DIV_OP_WIDTH-1:0] op,
    input logic                     sgn,
    input logic                     qn,
    input logic                     rn,
    input logic [31:0]              a_raw,
    input logic [31:0]              b_raw,
    input logic [31:0]              quo,
    input logic [31:0]              rem
  );
    logic [31:0] q;
    logic [31:0] r;
    q = (sgn && qn) ? (~quo + 32'd1) : quo;
    r = (sgn && rn) ? (~rem + 32'd1) : rem;
    if (b_raw == 32'd0) begin
      q = 32'hFFFF_FFFF;
      r = a_raw;
    end else if (sgn && (a_raw == 32'h8000_0000) && (b_raw == 32'hFFFF_FFFF)) begin
      q = 32'h8000_0000;
      r = 32'd0;
    end
    return ((op == `DIV_OP_REM) || (op == `DIV_OP_REMU)) ? r : q;
  endfunction

  // Operand decode, trial subtraction and final-step result
  always_comb begin
    in_signed = (DIVop == `DIV_OP_DIV) || (DIVop == `DIV_OP_REM);
    in_q_neg  = dividend[31] ^ divisor[31];
    in_r_neg  = dividend[31];
    a_mag_in  = (in_signed && dividend[31]) ? (~dividend + 32'd1) : dividend;
    b_mag_in  = (in_signed && divisor[31])  ? (~divisor + 32'd1)  : divisor;
    shifted   = {rem_q, quo_q[31]};
    diff      = shifted - {1'b0, b_mag_q};
    rem_step  = diff[32] ? shifted[31:0] : diff[31:0];
    quo_step  = {quo_q[30:0], ~diff[32]};
    calc_result = select_result(op_q, signed_q, q_neg_q, r_neg_q,
                                a_raw_q, b_raw_q, quo_step, rem_step);
  end

`ifdef DIV_EARLY_OUT_EN
  logic        early_in;
  logic [31:0] early_result;
  // Trivial cases: quotient 0 and remainder = |dividend| before sign fix-up
  always_comb begin
    early_in = (divisor == 32'd0) ||
               (in_signed && (dividend == 32'h8000_0000) && (divisor == 32'hFFFF_FFFF)) ||
               (a_mag_in < b_mag_in);
    early_result = select_result(DIVop, in_signed, in_q_neg, in_r_neg,
                                 dividend, divisor, 32'd0, a_mag_in);
  end
`else
  logic        early_in;
  logic [31:0] early_result;
  // Early-out disabled: every operation runs the full 32 steps
  always_comb begin
    early_in     = 1'b0;
    early_result = 32'd0;
  end
`endif

  // Control FSM and datapath registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      div_ready  <= 1'b0;
      div_result <= 32'd0;
      cnt        <= 6'd0;
      op_q       <= '0;
      signed_q   <= 1'b0;
      q_neg_q    <= 1'b0;
      r_neg_q    <= 1'b0;
      a_raw_q    <= 32'd0;
      b_raw_q    <= 32'd0;
      b_mag_q    <= 32'd0;
      rem_q      <= 32'd0;
      quo_q      <= 32'd0;
    end else begin
      div_ready <= 1'b0;
      case (state)
        IDLE: begin
          if (div_valid) begin
            op_q     <= DIVop;
            signed_q <= in_signed;
            q_neg_q  <= in_q_neg;
            r_neg_q  <= in_r_neg;
            a_raw_q  <= dividend;
            b_raw_q  <= divisor;
            b_mag_q  <= b_mag_in;
            quo_q    <= a_mag_in;
            rem_q    <= 32'd0;
            cnt      <= 6'd0;
            if (early_in) begin
              state      <= DONE;
              div_result <= early_result;
              div_ready  <= 1'b1;
            end else begin
              state <= CALC;
            end
          end
        end
        CALC: begin
          if (!div_valid) begin
            state <= IDLE;
          end else begin
            rem_q <= rem_step;
            quo_q <= quo_step;
            cnt   <= cnt + 6'd1;
            if (cnt == 6'd31) begin
              state      <= DONE;
              div_result <= calc_result;
              div_ready  <= 1'b1;
            end
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_div_unit_seq.sv
// tb_div_unit_seq: randomized + directed bench for div_unit_seq with an
// arithmetic reference model and an expected-result queue drained by a monitor.

`ifndef DIV_OP_WIDTH
`define DIV_OP_WIDTH 2
`define DIV_OP_DIV   2'b00
`define DIV_OP_DIVU  2'b01
`define DIV_OP_REM   2'b10
`define DIV_OP_REMU  2'b11
`endif

module tb_div_unit_seq;

  logic                     clk = 1'b0;
  logic                     reset;
  logic                     div_valid;
  logic [`DIV_OP_WIDTH-1:0] DIVop;
  logic [31:0]              dividend;
  logic [31:0]              divisor;
  logic [31:0]              div_result;
  logic                     div_ready;

  int          checks = 0;
  int          errors = 0;
  int          ready_seen = 0;
  logic [31:0] exp_q[$];
  logic [31:0] last_exp;
  logic [31:0] mon_e;
  logic        prev_ready = 1'b0;

  div_unit_seq dut (
    .clk       (clk),
    .reset     (reset),
    .div_valid (div_valid),
    .DIVop     (DIVop),
    .dividend  (dividend),
    .divisor   (divisor),
    .div_result(div_result),
    .div_ready (div_ready)
  );

  // Clock
  always #5 clk = ~clk;

  // Watchdog
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic bit is_signed_op(input logic [`DIV_OP_WIDTH-1:0] op);
    return (op == `DIV_OP_DIV) || (op == `DIV_OP_REM);
  endfunction

  // Reference model: RV32M semantics from plain arithmetic
  function automatic logic [31:0] ref_div(input logic [`DIV_OP_WIDTH-1:0] op,
                                          input logic [31:0] a, input logic [31:0] b);
    logic signed [31:0] sa;
    logic signed [31:0] sb;
    logic [31:0] q;
    logic [31:0] r;
    if (b == 32'd0) begin
      q = 32'hFFFF_FFFF;
      r = a;
    end else if (is_signed_op(op) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      q = 32'h8000_0000;
      r = 32'd0;
    end else if (is_signed_op(op)) begin
      sa = a;
      sb = b;
      q = sa / sb;
      r = sa % sb;
    end else begin
      q = a / b;
      r = a % b;
    end
    return ((op == `DIV_OP_REM) || (op == `DIV_OP_REMU)) ? r : q;
  endfunction

  function automatic int ref_latency(input logic [`DIV_OP_WIDTH-1:0] op,
                                     input logic [31:0] a, input logic [31:0] b);
`ifdef DIV_EARLY_OUT_EN
    logic [31:0] ma;
    logic [31:0] mb;
    ma = (is_signed_op(op) && a[31]) ? -a : a;
    mb = (is_signed_op(op) && b[31]) ? -b : b;
    if (b == 32'd0) return 1;
    if (is_signed_op(op) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    if (ma < mb) return 1;
    return 33;
`else
    return 33;
`endif
  endfunction

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 6))
      0: return 32'd0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return $urandom_range(0, 20);
      4: return -$urandom_range(1, 20);
      default: return $urandom;
    endcase
  endfunction

  // Monitor: pop expected result on every div_ready and check pulse width
  always @(negedge clk) begin
    if (reset) begin
      prev_ready = 1'b0;
    end else begin
      if (div_ready) begin
        ready_seen++;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_ready got=%h (no request outstanding)", div_result);
        end else begin
          mon_e = exp_q.pop_front();
          if (div_result !== mon_e) begin
            errors++;
            $display("FAIL result got=%h exp=%h", div_result, mon_e);
          end
        end
        checks++;
        if (prev_ready) begin
          errors++;
          $display("FAIL ready_width got=2+ cycles exp=1 cycle");
        end
      end
      prev_ready = div_ready;
    end
  end

  // Driver: issue one op, scramble inputs after acceptance, check latency and hold
  task automatic run_op(input logic [`DIV_OP_WIDTH-1:0] op,
                        input logic [31:0] a, input logic [31:0] b);
    logic [31:0] e;
    int lat;
    int lat_exp;
    e = ref_div(op, a, b);
    lat_exp = ref_latency(op, a, b);
    @(negedge clk);
    DIVop = op;
    dividend = a;
    divisor = b;
    div_valid = 1'b1;
    exp_q.push_back(e);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      if (!div_ready) begin
        DIVop = $urandom_range(0, 3);
        dividend = $urandom;
        divisor = $urandom;
      end
    end while (!div_ready && lat < 100);
    checks++;
    if (!div_ready) begin
      errors++;
      $display("FAIL timeout op=%0d a=%h b=%h got=no ready exp=ready at %0d", op, a, b, lat_exp);
    end else if (lat != lat_exp) begin
      errors++;
      $display("FAIL latency op=%0d a=%h b=%h got=%0d exp=%0d", op, a, b, lat, lat_exp);
    end
    div_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (div_result !== e) begin
      errors++;
      $display("FAIL hold op=%0d a=%h b=%h got=%h exp=%h", op, a, b, div_result, e);
    end
    last_exp = e;
  endtask

  // Start a long op and leave it running for n CALC cycles
  task automatic start_long(input int n);
    @(negedge clk);
    DIVop = `DIV_OP_DIVU;
    dividend = 32'd1000000;
    divisor = 32'd3;
    div_valid = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  initial begin
    int seen_before;
    reset = 1'b1;
    div_valid = 1'b0;
    DIVop = `DIV_OP_DIVU;
    dividend = 32'd0;
    divisor = 32'd0;
    last_exp = 32'd0;
    repeat (3) @(negedge clk);
    checks++;
    if (div_ready !== 1'b0) begin errors++; $display("FAIL reset_ready got=%b exp=0", div_ready); end
    checks++;
    if (div_result !== 32'd0) begin errors++; $display("FAIL reset_result got=%h exp=0", div_result); end
    reset = 1'b0;

    // Directed cases
    run_op(`DIV_OP_DIVU, 32'd100, 32'd7);
    run_op(`DIV_OP_REMU, 32'd100, 32'd7);
    run_op(`DIV_OP_DIV,  32'hFFFF_FFF9, 32'd2);
    run_op(`DIV_OP_REM,  32'hFFFF_FFF9, 32'd2);
    run_op(`DIV_OP_REM,  32'd7, 32'hFFFF_FFFE);
    run_op(`DIV_OP_DIV,  32'd5, 32'd0);
    run_op(`DIV_OP_REM,  32'd5, 32'd0);
    run_op(`DIV_OP_REMU, 32'h8000_0000, 32'd0);
    run_op(`DIV_OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF);
    run_op(`DIV_OP_REM,  32'h8000_0000, 32'hFFFF_FFFF);
    run_op(`DIV_OP_DIVU, 32'd0, 32'd9);
    run_op(`DIV_OP_REM,  32'hFFFF_FFFD, 32'd10);

    // Abort at CALC cycle 10: no pulse, result unchanged
    seen_before = ready_seen;
    start_long(10);
    div_valid = 1'b0;
    repeat (40) @(negedge clk);
    checks++;
    if (ready_seen != seen_before) begin
      errors++;
      $display("FAIL abort_pulse got=%0d pulses exp=0", ready_seen - seen_before);
    end
    checks++;
    if (div_result !== last_exp) begin
      errors++;
      $display("FAIL abort_result got=%h exp=%h", div_result, last_exp);
    end

    // Reset at CALC cycle 20
    seen_before = ready_seen;
    start_long(20);
    reset = 1'b1;
    div_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (div_ready !== 1'b0) begin errors++; $display("FAIL midreset_ready got=%b exp=0", div_ready); end
    checks++;
    if (div_result !== 32'd0) begin errors++; $display("FAIL midreset_result got=%h exp=0", div_result); end
    reset = 1'b0;
    repeat (40) @(negedge clk);
    checks++;
    if (ready_seen != seen_before) begin
      errors++;
      $display("FAIL midreset_pulse got=%0d pulses exp=0", ready_seen - seen_before);
    end
    run_op(`DIV_OP_DIVU, 32'd9, 32'd3);

    // Back-to-back with a one-cycle gap
    seen_before = ready_seen;
    run_op(`DIV_OP_DIVU, 32'hFFFF_FFFF, 32'd1);
    run_op(`DIV_OP_REMU, 32'd10, 32'd3);
    checks++;
    if (ready_seen - seen_before != 2) begin
      errors++;
      $display("FAIL b2b_pulses got=%0d exp=2", ready_seen - seen_before);
    end

    // Randomized operations
    for (int i = 0; i < 40; i++) begin
      run_op($urandom_range(0, 3), pick_operand(), pick_operand());
    end

    repeat (3) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL leftover_expected got=%0d exp=0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
